sr_bank_driver: RTL
===================

# sr_bank_driver

Write-side controller for a bank of SR flip-flops. It accepts a target word over a valid/ready handshake and compares it with the bank's current Q. It then drives per-bit Set/Reset pulses so the bank reaches that word, never asserting S and R together on any bit. After a settle window it reads Q back, retries on mismatch, and reports done or error. It sits between register-update logic and any SR flip-flop bank in the design.

## Interface
- WIDTH, 8: number of SR flip-flops in the bank.
- SETTLE_CYCLES, 1: idle cycles after each drive pulse before readback. Must be ≥1.
- RETRY_MAX, 2: re-drive attempts after a failed readback. 0 means no retry.

- CLK  in  1  clock; all logic on posedge.
- RST_N  in  1  synchronous, active-low reset.
- tgt_valid  in  1  target word offered.
- tgt_ready  out  1  driver can accept a target.
- tgt_data  in  WIDTH  desired Q for the bank.
- q_fb  in  WIDTH  Q outputs of the bank.
- S  out  WIDTH  per-bit Set drive, registered.
- R  out  WIDTH  per-bit Reset drive, registered.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse: bank matches target.
- err  out  1  one-cycle pulse: retries exhausted.
- err_mask  out  WIDTH  q_fb ^ target at the failing check. Holds until the next accept or reset.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK.
- **IDLE**
  - tgt_ready=1; S=R=0.
  - On tgt_valid&tgt_ready: latch tgt_data into tgt_r, clear retry count and err_mask.
  - Compute set_m = tgt_data & ~q_fb and clr_m = ~tgt_data & q_fb.
  - If set_m|clr_m == 0, go to CHECK. Otherwise go to DRIVE.
- **DRIVE** (exactly 1 cycle): S=set_m, R=clr_m. Next state is SETTLE.
- **SETTLE**: S=R=0 for SETTLE_CYCLES cycles, counted by a down-counter. Then go to CHECK.
- **CHECK**: sample q_fb.
  - q_fb == tgt_r: pulse done, go to IDLE.
  - Mismatch and retry < RETRY_MAX: retry++, recompute the masks from the current q_fb and tgt_r, go to DRIVE.
  - Mismatch and retry == RETRY_MAX: pulse err, err_mask = q_fb ^ tgt_r, go to IDLE.
- **Invariants**
  - (S & R) == 0 on every cycle, including reset and retries.
  - Bits already correct receive neither S nor R (hold encoding).
- tgt_ready is low outside IDLE. Targets offered while busy are not accepted, and tgt_valid must stay high until accepted.
- done and err are never high in the same cycle.
- **Reset values** (RST_N low at a posedge): next cycle state=IDLE, S=0, R=0, busy=0, done=0, err=0, err_mask=0, retry=0, tgt_r=0. tgt_ready=0 while RST_N is low.
- **Reset mid-operation**: abort the transfer immediately. No done or err pulse is issued for it, and S/R drop on the next edge.

## Timing
- Accept edge at the end of cycle k.
- DRIVE occupies cycle k+1, with S/R high during it. The bank samples S/R at the end of k+1.
- SETTLE occupies cycles k+2 … k+1+SETTLE_CYCLES.
- CHECK is in cycle k+2+SETTLE_CYCLES. done/err is high in the following cycle, which is also IDLE with tgt_ready=1.
- Latency, accept to done (no retry): 3+SETTLE_CYCLES cycles. Each retry adds 2+SETTLE_CYCLES.
- No-change target: CHECK in k+1, done in k+2.
- Back-to-back: a new accept is possible in the same cycle done is high.

## Structure
- Package sr_drv_pkg holds:
  - the state enum;
  - the 2-bit per-bit drive encoding constants: HOLD=2'b00, SET=2'b10, RST=2'b01, ILLEGAL=2'b11, in {S,R} order;
  - a function checking that no bit uses ILLEGAL, used by assertions.
- Sub-module sr_mask_gen is purely combinational: tgt and q in, set_m and clr_m out. It is instanced once and shared by IDLE and retry.
- The bench closes the loop with a behavioural WIDTH-bit SR flop bank model on CLK that can force stuck bits.

## Test plan
Bench settings: WIDTH=8, SETTLE_CYCLES=1, RETRY_MAX=2.
- Bank 8'h00, target 8'hA5 → one DRIVE cycle with S=8'hA5, R=8'h00; done 4 cycles after accept; err=0.
- Bank 8'hF0, target 8'h3C → S=8'h0C, R=8'hC0 in the same cycle; S&R==0 asserted every cycle; done at +4.
- Bank 8'h5A, target 8'h5A → S and R never asserted; done 2 cycles after accept.
- Bit 3 stuck at 0, target 8'h08 → 3 DRIVE pulses with S=8'h08; err pulse; err_mask=8'h08; done never asserted.
- RST_N low during SETTLE → S=R=0 and state IDLE next cycle; no done or err pulse; a fresh target of 8'hFF completes normally.
- tgt_valid held high with a second target (8'h11) queued behind 8'h22 → second accepted in the done cycle of the first; bank ends at 8'h11.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg
// Shared definitions for the SR flip-flop bank driver:
//   - state_t     : controller states (IDLE, DRIVE, SETTLE, CHECK)
//   - drive_enc_t : 2-bit per-bit drive code in {S,R} order
//   - HOLD/SET/RST/ILLEGAL : the four drive codes
//   - drive_legal : true when no bit of an S/R pair carries ILLEGAL
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  typedef logic [1:0] drive_enc_t;

  localparam drive_enc_t HOLD    = 2'b00;
  localparam drive_enc_t SET     = 2'b10;
  localparam drive_enc_t RST     = 2'b01;
  localparam drive_enc_t ILLEGAL = 2'b11;

  // Widest bank the legality checker covers; narrower banks are zero-extended.
  localparam int MAX_WIDTH = 64;

  // An SR flop driven with S and R together has an undefined next state, so
  // every bit pair must avoid the ILLEGAL code.
  function automatic logic drive_legal(input logic [MAX_WIDTH-1:0] s,
                                       input logic [MAX_WIDTH-1:0] r);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if ({s[i], r[i]} == ILLEGAL) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sr_mask_gen.sv
// sr_mask_gen
// Purely combinational per-bit drive decision for an SR bank.
// Ports:
//   tgt   in  WIDTH  desired bank contents
//   q     in  WIDTH  current bank contents
//   set_m out WIDTH  bits that must be set   (tgt=1, q=0)
//   clr_m out WIDTH  bits that must be reset (tgt=0, q=1)
// Bits that already match get HOLD, so they see neither S nor R.
module sr_mask_gen
  import sr_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] set_m,
  output logic [WIDTH-1:0] clr_m
);

  // Pick a drive code per bit, then split it into the S and R masks. The code
  // can only ever be HOLD, SET or RST, so set_m & clr_m is zero by construction.
  always_comb begin
    drive_enc_t enc;
    enc   = HOLD;
    set_m = '0;
    clr_m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (tgt[i] == q[i]) enc = HOLD;
      else if (tgt[i])    enc = SET;
      else                enc = RST;
      set_m[i] = enc[1];
      clr_m[i] = enc[0];
    end
  end

endmodule

// File: rtl/sr_bank_driver.sv
// sr_bank_driver
// Write-side controller for a bank of SR flip-flops. Accepts a target word,
// pulses per-bit Set/Reset for one cycle, waits a settle window, reads the
// bank back and retries up to RETRY_MAX times before reporting an error.
// Ports:
//   CLK        in   1      clock, all logic on posedge
//   RST_N      in   1      synchronous active-low reset
//   tgt_valid  in   1      target word offered
//   tgt_ready  out  1      driver idle and able to accept
//   tgt_data   in   WIDTH  desired bank Q
//   q_fb       in   WIDTH  bank Q feedback
//   S, R       out  WIDTH  registered per-bit Set/Reset drive
//   busy       out  1      controller not in IDLE
//   done       out  1      one-cycle pulse, bank matches target
//   err        out  1      one-cycle pulse, retries exhausted
//   err_mask   out  WIDTH  mismatching bits at the failing check
module sr_bank_driver
  import sr_drv_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int RETRY_MAX     = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  state_t             state;
  logic [WIDTH-1:0]   tgt_r;
  logic [CNT_W-1:0]   settle_cnt;
  logic [RETRY_W-1:0] retry;
  logic [WIDTH-1:0]   mask_tgt;
  logic [WIDTH-1:0]   set_m;
  logic [WIDTH-1:0]   clr_m;

  // One mask generator serves both the initial accept and every retry: in
  // IDLE it compares the offered word, afterwards the latched target.
  always_comb begin
    mask_tgt = (state == IDLE) ? tgt_data : tgt_r;
  end

  sr_mask_gen #(.WIDTH(WIDTH)) u_mask_gen (
    .tgt   (mask_tgt),
    .q     (q_fb),
    .set_m (set_m),
    .clr_m (clr_m)
  );

  // Ready is held low during reset so nothing is handed over while the
  // controller is being cleared.
  always_comb begin
    tgt_ready = RST_N && (state == IDLE);
    busy      = (state != IDLE);
  end

  // Controller FSM. S/R, done and err default low every cycle so each is a
  // single-cycle pulse; only DRIVE entry loads a non-zero S/R. A word that
  // already matches the bank skips straight to CHECK without any drive.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      tgt_r      <= '0;
      settle_cnt <= '0;
      retry      <= '0;
      S          <= '0;
      R          <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_mask   <= '0;
    end else begin
      S    <= '0;
      R    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_r    <= tgt_data;
            retry    <= '0;
            err_mask <= '0;
            if ((set_m | clr_m) == '0) begin
              state <= CHECK;
            end else begin
              S     <= set_m;
              R     <= clr_m;
              state <= DRIVE;
            end
          end
        end
        DRIVE: begin
          settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CHECK;
          else settle_cnt <= settle_cnt - CNT_W'(1);
        end
        CHECK: begin
          if (q_fb == tgt_r) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry < RETRY_W'(RETRY_MAX)) begin
            retry <= retry + RETRY_W'(1);
            S     <= set_m;
            R     <= clr_m;
            state <= DRIVE;
          end else begin
            err      <= 1'b1;
            err_mask <= q_fb ^ tgt_r;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Guard the bank against ever seeing S and R together, and keep the two
  // completion pulses mutually exclusive.
  always_ff @(posedge CLK) begin
    assert (drive_legal(MAX_WIDTH'(S), MAX_WIDTH'(R)));
    assert (!(done && err));
  end

endmodule
